// File: rtl/alu_pkg.sv
// Shared opcode/funct encodings, internal op enum, FSM states and the
// combinational instruction decoder for alu_mdu_seq.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [4:0] {
    ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA,
    MFHI, MFLO, MUL, MULU, DIV, DIVU, ILL
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} mdu_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    ovf_en;
  } dec_t;

  // Only add, sub and addi report signed overflow; the unsigned forms and
  // the branch/load-store address paths reuse the same adder silently.
  function automatic dec_t decode(input logic [5:0] opc, input logic [5:0] fn);
    dec_t d;
    d.op     = ILL;
    d.ovf_en = 1'b0;
    if (opc == OP_RTYPE) begin
      case (fn)
        FN_ADD:   begin d.op = ADD; d.ovf_en = 1'b1; end
        FN_ADDU:  d.op = ADD;
        FN_SUB:   begin d.op = SUB; d.ovf_en = 1'b1; end
        FN_SUBU:  d.op = SUB;
        FN_AND:   d.op = AND;
        FN_OR:    d.op = OR;
        FN_XOR:   d.op = XOR;
        FN_NOR:   d.op = NOR;
        FN_SLT:   d.op = SLT;
        FN_SLTU:  d.op = SLTU;
        FN_SLL:   d.op = SLL;
        FN_SRL:   d.op = SRL;
        FN_SRA:   d.op = SRA;
        FN_MFHI:  d.op = MFHI;
        FN_MFLO:  d.op = MFLO;
        FN_MULT:  d.op = MUL;
        FN_MULTU: d.op = MULU;
        FN_DIV:   d.op = DIV;
        FN_DIVU:  d.op = DIVU;
        default:  d.op = ILL;
      endcase
    end else begin
      case (opc)
        OP_ADDI:                  begin d.op = ADD; d.ovf_en = 1'b1; end
        OP_ADDIU, OP_LW, OP_SW:   d.op = ADD;
        OP_BEQ, OP_BNE:           d.op = SUB;
        OP_ANDI:                  d.op = AND;
        OP_ORI:                   d.op = OR;
        OP_XORI:                  d.op = XOR;
        OP_SLTI:                  d.op = SLT;
        OP_SLTIU:                 d.op = SLTU;
        default:                  d.op = ILL;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Unsigned iterative multiply (shift-add) / divide (restoring) engine.
// Loads on start, runs WIDTH iterations, done is high during the last one.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic             busy;
  logic             div_mode;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  // hi_q is the partial product / remainder, lo_q the multiplier / quotient.
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, mcand};
    nxt_hi  = add_sum[WIDTH:1];
    nxt_lo  = {add_sum[0], lo_q[WIDTH-1:1]};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh[WIDTH-1:0];
        nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      busy     <= 1'b0;
      div_mode <= 1'b0;
      mcand    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (start) begin
      cnt      <= '0;
      busy     <= 1'b1;
      div_mode <= is_div;
      mcand    <= op_b;
      hi_q     <= '0;
      lo_q     <= op_a;
    end else if (busy) begin
      hi_q <= nxt_hi;
      lo_q <= nxt_lo;
      if (cnt == LAST) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done   = busy && (cnt == LAST);
  assign res_hi = hi_q;
  assign res_lo = lo_q;

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage ALU with registered single-cycle ops and an iterative MDU
// owning the HI/LO registers; valid/ready stalls the pipe during mult/div.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB = WIDTH - 1;

  mdu_state_e         state;
  mdu_state_e         state_n;
  dec_t               dec;
  logic               is_mdu;
  logic               is_signed;
  logic               is_div;
  logic               mdu_start;
  logic               mdu_done;
  logic [WIDTH-1:0]   mdu_hi;
  logic [WIDTH-1:0]   mdu_lo;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               a_neg_q;
  logic               b_neg_q;
  logic               b_zero_q;
  logic               div_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   dif;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic               sc_ill;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign dec       = decode(opcode, func_field);
  assign is_mdu    = (dec.op == MUL) || (dec.op == MULU) || (dec.op == DIV) || (dec.op == DIVU);
  assign is_signed = (dec.op == MUL) || (dec.op == DIV);
  assign is_div    = (dec.op == DIV) || (dec.op == DIVU);
  assign a_neg     = is_signed && A[MSB];
  assign b_neg     = is_signed && B[MSB];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;
  assign sum       = A + B;
  assign dif       = A - B;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (dec.op)
      ADD: begin
        sc_res = sum;
        sc_ovf = dec.ovf_en && (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      SUB: begin
        sc_res = dif;
        sc_ovf = dec.ovf_en && (A[MSB] != B[MSB]) && (dif[MSB] != A[MSB]);
      end
      AND:  sc_res = A & B;
      OR:   sc_res = A | B;
      XOR:  sc_res = A ^ B;
      NOR:  sc_res = ~(A | B);
      SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      SLL:  sc_res = B << A[SHW-1:0];
      SRL:  sc_res = B >> A[SHW-1:0];
      SRA:  sc_res = $signed(B) >>> A[SHW-1:0];
      MFHI: sc_res = hi;
      MFLO: sc_res = lo;
      ILL:  sc_ill = 1'b1;
      default: sc_res = '0;
    endcase
  end

  // Divide by zero bypasses sign fixup so hi returns the raw dividend.
  assign prod     = {mdu_hi, mdu_lo};
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (b_zero_q) begin
        fix_lo = '1;
        fix_hi = a_q;
      end else begin
        fix_lo = (a_neg_q ^ b_neg_q) ? -mdu_lo : mdu_lo;
        fix_hi = a_neg_q ? -mdu_hi : mdu_hi;
      end
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    mdu_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && is_mdu) begin
          mdu_start = 1'b1;
          state_n   = BUSY;
        end
      end
      BUSY:    if (mdu_done) state_n = FIXUP;
      FIXUP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      div_q     <= 1'b0;
      a_q       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && in_valid) begin
        if (is_mdu) begin
          a_neg_q  <= a_neg;
          b_neg_q  <= b_neg;
          b_zero_q <= (B == '0);
          div_q    <= is_div;
          a_q      <= A;
        end else begin
          out_valid <= 1'b1;
          result    <= sc_res;
          zero      <= (sc_res == '0);
          ovf       <= sc_ovf;
          illegal   <= sc_ill;
        end
      end else if (state == FIXUP) begin
        out_valid <= 1'b1;
        result    <= fix_lo;
        zero      <= (fix_lo == '0);
        ovf       <= 1'b0;
        illegal   <= 1'b0;
        hi        <= fix_hi;
        lo        <= fix_lo;
      end
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .is_div (is_div),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .done   (mdu_done),
    .res_hi (mdu_hi),
    .res_lo (mdu_lo)
  );

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, negedge
// monitors pop and compare on every out_valid pulse (32- and 16-bit DUTs).
module tb_alu_mdu_seq;

  typedef struct {
    int          tag;
    logic [31:0] result;
    logic        ovf;
    logic        illegal;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, zero, ovf, illegal;
  logic [5:0]  opcode, func_field;
  logic [31:0] a_in, b_in, result, hi, lo;

  logic        v16, rdy16, ov16, z16, ovf16, ill16;
  logic [5:0]  op16, fn16;
  logic [15:0] a16, b16, res16, hi16, lo16;

  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n;

  alu_mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func_field(func_field), .A(a_in), .B(b_in),
    .out_valid(out_valid), .result(result), .zero(zero), .ovf(ovf),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  alu_mdu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .opcode(op16), .func_field(fn16), .A(a16), .B(b16),
    .out_valid(ov16), .result(res16), .zero(z16), .ovf(ovf16),
    .illegal(ill16), .hi(hi16), .lo(lo16)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q32.size() == 0) begin
        chk("unexpected_out_valid32", 32'd1, 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk($sformatf("v%0d result", e32.tag), result, e32.result);
        chk($sformatf("v%0d zero", e32.tag), {31'b0, zero}, {31'b0, e32.result == 32'd0});
        chk($sformatf("v%0d ovf", e32.tag), {31'b0, ovf}, {31'b0, e32.ovf});
        chk($sformatf("v%0d illegal", e32.tag), {31'b0, illegal}, {31'b0, e32.illegal});
        chk($sformatf("v%0d hi", e32.tag), hi, e32.hi);
        chk($sformatf("v%0d lo", e32.tag), lo, e32.lo);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16) begin
      if (q16.size() == 0) begin
        chk("unexpected_out_valid16", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        chk($sformatf("v%0d result", e16.tag), {16'b0, res16}, e16.result);
        chk($sformatf("v%0d zero", e16.tag), {31'b0, z16}, {31'b0, e16.result == 32'd0});
        chk($sformatf("v%0d illegal", e16.tag), {31'b0, ill16}, {31'b0, e16.illegal});
        chk($sformatf("v%0d hi", e16.tag), {16'b0, hi16}, e16.hi);
        chk($sformatf("v%0d lo", e16.tag), {16'b0, lo16}, e16.lo);
      end
    end
  end

  task automatic send(input int tag, input logic [5:0] opc, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                      input logic ov, input logic il, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.tag = tag; e.result = r; e.ovf = ov; e.illegal = il; e.hi = h; e.lo = l;
    opcode = opc; func_field = fn; a_in = a; b_in = b; in_valid = 1'b1;
    q32.push_back(e);
    @(negedge clk);
  endtask

  // n counts edges from the accept edge (inclusive) to the edge that raises out_valid.
  task automatic wait_out(output int cnt);
    cnt = 1;
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (cnt == 10) in_valid = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = '0; func_field = '0; a_in = '0; b_in = '0;
    v16 = 1'b0; op16 = '0; fn16 = '0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst zero", {31'b0, zero}, 32'd1);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);

    send(1, 6'h00, 6'h21, 32'd5, 32'd7, 32'd12, 0, 0, 0, 0);
    chk("v1 latency", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);

    send(2, 6'h00, 6'h23, 32'd10, 32'd3, 32'd7, 0, 0, 0, 0);
    chk("b2b pulse1", {31'b0, out_valid}, 32'd1);
    send(3, 6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0);
    chk("b2b pulse2", {31'b0, out_valid}, 32'd1);
    send(4, 6'h00, 6'h00, 32'd4, 32'd1, 32'd16, 0, 0, 0, 0);
    chk("b2b pulse3", {31'b0, out_valid}, 32'd1);
    send(5, 6'h00, 6'h03, 32'd4, 32'h80000000, 32'hF8000000, 0, 0, 0, 0);
    chk("b2b pulse4", {31'b0, out_valid}, 32'd1);
    send(6, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, 0);
    send(7, 6'h00, 6'h2B, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0, 0);
    send(8, 6'h00, 6'h27, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
    send(9, 6'h04, 6'h00, 32'h1234, 32'h1234, 32'd0, 0, 0, 0, 0);
    send(10, 6'h00, 6'h20, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 0, 0);
    send(11, 6'h08, 6'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 0, 0);
    send(12, 6'h00, 6'h21, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);

    // mult -3*4; keep an addu request asserted during BUSY, it must be ignored
    send(13, 6'h00, 6'h18, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF4);
    chk("mult busy in_ready", {31'b0, in_ready}, 32'd0);
    func_field = 6'h21; a_in = 32'd1; b_in = 32'd1;
    wait_out(n);
    chk("mult latency", n, 32'd34);
    chk("mult in_ready back", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);

    send(14, 6'h00, 6'h12, 32'd0, 32'd0, 32'hFFFFFFF4, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF4);
    send(15, 6'h00, 6'h10, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF4);
    in_valid = 1'b0;

    send(16, 6'h00, 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    in_valid = 1'b0;
    wait_out(n);
    chk("div latency", n, 32'd34);
    @(negedge clk);

    send(17, 6'h00, 6'h1B, 32'd100, 32'd0, 32'hFFFFFFFF, 0, 0, 32'd100, 32'hFFFFFFFF);
    in_valid = 1'b0;
    wait_out(n);
    chk("divu latency", n, 32'd34);
    @(negedge clk);

    send(18, 6'h3F, 6'h00, 32'd9, 32'd9, 32'd0, 0, 1, 32'd100, 32'hFFFFFFFF);
    in_valid = 1'b0;
    @(negedge clk);

    // abort a multu mid-iteration with an asynchronous reset
    opcode = 6'h00; func_field = 6'h19; a_in = 32'd5; b_in = 32'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("multu busy", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst zero", {31'b0, zero}, 32'd1);
    chk("midrst ovf", {31'b0, ovf}, 32'd0);
    chk("midrst illegal", {31'b0, illegal}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(19, 6'h00, 6'h21, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0);
    chk("v19 latency", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);

    // 16-bit instance: mult -3*4 completes in WIDTH+2 = 18 edges
    begin
      exp_t e;
      e.tag = 20; e.result = 32'h0000FFF4; e.ovf = 0; e.illegal = 0;
      e.hi = 32'h0000FFFF; e.lo = 32'h0000FFF4;
      q16.push_back(e);
    end
    op16 = 6'h00; fn16 = 6'h18; a16 = 16'hFFFD; b16 = 16'd4; v16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    n = 1;
    while (!ov16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mult16 latency", n, 32'd18);
    @(negedge clk);

    repeat (3) @(negedge clk);
    chk("q32 drained", q32.size(), 32'd0);
    chk("q16 drained", q16.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
# alu_mdu_seq

Parametrised, pipelined successor to the single-cycle MIPS ALU: decodes `opcode`/`func_field` internally, executes single-cycle integer ops with a registered 1-cycle latency, and adds an iterative multiply/divide unit with architectural HI/LO registers. It sits in the EX stage of the 32-bit MIPS datapath. A valid/ready handshake lets the pipeline stall while a multi-cycle op is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be ≥ 8 and even.
- `SHW`, $clog2(WIDTH): shift-amount width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `opcode`  in  6  MIPS primary opcode.
- `func_field`  in  6  MIPS funct, used when `opcode`=0.
- `A`  in  WIDTH  operand rs; also shift amount (`A[SHW-1:0]`).
- `B`  in  WIDTH  operand rt/immediate (already extended).
- `out_valid`  out  1  one-cycle pulse: `result`/`zero`/`ovf`/`illegal` valid.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result`==0.
- `ovf`  out  1  signed overflow (add/sub/addi only).
- `illegal`  out  1  unsupported opcode/funct.
- `hi`, `lo`  out  WIDTH each  HI/LO registers.

## Operation
- Decoded ops. R-type funct: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra, 0x10 mfhi, 0x12 mflo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
- I-type opcodes: 0x08 addi, 0x09 addiu, 0x0C andi, 0x0D ori, 0x0E xori, 0x0A slti, 0x0B sltiu, 0x04/0x05 beq/bne → sub, 0x23/0x2B lw/sw → addu.
- Shifts: value `B`, amount `A[SHW-1:0]`. sra is arithmetic.
- Arithmetic is modulo 2^WIDTH. `ovf` is set for add/sub/addi on signed overflow; `result` is still written.
- slt/sltu: `result` = {WIDTH-1 zeros, flag}.
- mult/multu: {hi, lo} = full 2·WIDTH-bit product; `result` = new `lo`.
- div/divu: `lo` = quotient (truncates toward zero); `hi` = remainder (sign follows dividend).
- Divide by zero: `lo` = all ones, `hi` = `A`, no error flag.
- Signed multi-cycle ops: take magnitudes, run an unsigned shift-add / restoring-divide loop, then fix signs in FIXUP.
- Illegal code: `result` = 0, `illegal` = 1, HI/LO unchanged; still completes in 1 cycle.
- FSM states: IDLE, BUSY, FIXUP.
  - IDLE → BUSY on accept of mult/div.
  - BUSY → FIXUP when the iteration counter reaches WIDTH−1.
  - FIXUP → IDLE unconditionally.
  - Single-cycle ops stay in IDLE.

## Timing
- Accept occurs on an edge with `in_valid`=1 and `in_ready`=1. Operands are captured at that edge. `in_valid` in any other state is ignored, with no queuing.
- Single-cycle op accepted at edge k: `out_valid`=1 in the cycle after edge k. Back-to-back accepts are sustained every cycle.
- mfhi/mflo return HI/LO as of the accept edge.
- Multi-cycle op accepted at edge k:
  - `in_ready`=0 after edge k.
  - Edges k+1..k+WIDTH perform the iterations.
  - Edge k+WIDTH+1 performs FIXUP and writes `result`, `hi`, `lo`.
  - `out_valid`=1 and `in_ready`=1 in the following cycle. Total latency is WIDTH+2 edges.
- A new op may be accepted in the same cycle `out_valid` pulses.
- `out_valid` has no backpressure; consumers must sample it.
- `result`, `zero`, `ovf`, `illegal` hold their values until the next completion.
- Reset (any time, including mid-BUSY): state=IDLE, the op is aborted, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1, `ovf`=0, `illegal`=0, `hi`=0, `lo`=0, counter=0.

## Structure
- Package `alu_pkg`:
  - opcode/funct localparams.
  - `alu_op_e` enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MFHI, MFLO, MUL, MULU, DIV, DIVU, ILL).
  - `mdu_state_e` enum.
- Decode is a combinational function in the package.
- Sub-module `mdu_iter` contains the WIDTH-step shift-add/restoring-divide datapath and counter, with a start/done handshake. The top module holds the FSM, single-cycle datapath, and output registers.

## Test plan
- Reset, then addu A=5, B=7 → `result`=12, `zero`=0, `out_valid` one cycle after accept; four back-to-back ops yield four consecutive `out_valid` pulses.
- beq path (opcode 0x04), A=B=0x1234 → `result`=0, `zero`=1. Then add 0x7FFFFFFF+1 → `result`=0x80000000, `ovf`=1.
- mult A=−3, B=4 (WIDTH=32) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF4, `out_valid` exactly 34 edges after accept. `in_valid` held high during BUSY is ignored; mflo next → 0xFFFFFFF4.
- div A=−7, B=2 → `lo`=−3, `hi`=−1. divu A=100, B=0 → `lo`=0xFFFFFFFF, `hi`=100.
- Assert `rst` at iteration 10 of a multu → all outputs at reset values immediately, `in_ready`=1; a following addu completes normally.
- opcode 0x3F → `illegal`=1, `result`=0, HI/LO unchanged. Repeat the mult test with WIDTH=16 → latency 18.
